// File: rtl/keypad_scanner.sv
// keypad_scanner: multiplexed 4x4 matrix keypad scanner.
// Drives one column at a time and reads the row lines back through a
// 2-flop synchronizer. A candidate key must match on DEBOUNCE_TICKS
// consecutive column samples before it is reported. Its release must
// likewise be empty on DEBOUNCE_TICKS consecutive samples.
// Handshake: key_valid is a one-cycle strobe with no back-pressure. key is
// stable from the key_valid cycle until the next accepted press, so a
// consumer may sample key on any cycle where key_valid is high.
module keypad_scanner #(
  parameter int SCAN_DIV       = 4096,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  logic [3:0]       rows_meta_q;
  logic [3:0]       rows_sync_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       cand_row_q;
  logic [3:0]       cols_q;
  logic [3:0]       cols_next;
  logic [3:0]       key_q;
  logic             key_valid_q;
  logic             key_held_q;

  logic             tick;
  logic             hit;
  logic [1:0]       hit_row;
  logic [1:0]       col_idx;

  // Column slot timing: tick marks the last cycle of each slot.
  assign tick      = (div_q == DIV_LAST);
  assign div_d     = tick ? '0 : div_q + DIV_W'(1);
  assign hit       = |rows_sync_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign cols_next = {cols_q[2:0], cols_q[3]};

  // Lowest-index active row wins when several keys share a column.
  always_comb begin
    hit_row = 2'd0;
    if (rows_sync_q[0])      hit_row = 2'd0;
    else if (rows_sync_q[1]) hit_row = 2'd1;
    else if (rows_sync_q[2]) hit_row = 2'd2;
    else if (rows_sync_q[3]) hit_row = 2'd3;
  end

  // Encode the one-hot column drive into its index.
  always_comb begin
    col_idx = 2'd0;
    case (cols_q)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Synchronizer, divider and the scan/debounce/pressed FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_meta_q <= '0;
      rows_sync_q <= '0;
      div_q       <= '0;
      state_q     <= ST_SCAN;
      cnt_q       <= '0;
      cand_row_q  <= '0;
      cols_q      <= 4'b0001;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      rows_meta_q <= rows;
      rows_sync_q <= rows_meta_q;
      div_q       <= div_d;
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          ST_SCAN: begin
            if (hit) begin
              cand_row_q <= hit_row;
              if (DEBOUNCE_TICKS == 1) begin
                key_q       <= {hit_row, col_idx};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= '0;
                state_q     <= ST_PRESSED;
              end else begin
                cnt_q   <= CNT_W'(1);
                state_q <= ST_DEBOUNCE;
              end
            end else begin
              cols_q <= cols_next;
            end
          end
          ST_DEBOUNCE: begin
            if (hit && (hit_row == cand_row_q)) begin
              if (cnt_inc == CNT_TARGET) begin
                key_q       <= {cand_row_q, col_idx};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= '0;
                state_q     <= ST_PRESSED;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q   <= '0;
              cols_q  <= cols_next;
              state_q <= ST_SCAN;
            end
          end
          ST_PRESSED: begin
            if (hit) begin
              cnt_q <= '0;
            end else if (cnt_inc == CNT_TARGET) begin
              key_held_q <= 1'b0;
              cnt_q      <= '0;
              cols_q     <= cols_next;
              state_q    <= ST_SCAN;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= ST_SCAN;
          end
        endcase
      end
    end
  end

  assign cols      = cols_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
